// File: rtl/segasys1_mainio_pkg.sv
// Port map constants and helpers shared by the System 1 main-CPU I/O block.
package segasys1_mainio_pkg;

   localparam logic [4:0] PA_SCMD      = 5'h18;
   localparam logic [4:0] PA_VMODE     = 5'h19;
   localparam logic [4:0] PA_STAT      = 5'h1A;
   localparam logic [4:0] DSW_BASE_DEF = 5'h0C;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >>> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/segasys1_scmd_fifo.sv
// Sound-command FIFO: a pop on empty is ignored, and a push to a full FIFO is
// dropped unless a pop frees the slot in the same cycle.
module segasys1_scmd_fifo
   import segasys1_mainio_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [WIDTH-1:0]      data_i,
   output logic                  empty_o,
   output logic                  drop_o,
   output logic [clog2(DEPTH):0] count_o,
   output logic [WIDTH-1:0]      head_o
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             full_s, push_ok_s, pop_ok_s;

   assign full_s    = (cnt_q == FULL_CNT);
   assign empty_o   = (cnt_q == {(AW+1){1'b0}});
   assign pop_ok_s  = pop_i & ~empty_o;
   assign push_ok_s = push_i & (~full_s | pop_ok_s);
   assign drop_o    = push_i & ~push_ok_s;
   assign count_o   = cnt_q;
   assign head_o    = empty_o ? {WIDTH{1'b0}} : mem_q[rd_q];

   // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (pop_ok_s) rd_d = rd_q + AW'(1);
      else          rd_d = rd_q;
      if (push_ok_s) wr_d = wr_q + AW'(1);
      else           wr_d = wr_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage array; contents are don't-care while unoccupied.
   always_ff @(posedge clk_i) begin
      if (push_ok_s) mem_q[wr_q] <= data_i;
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q  <= {AW{1'b0}};
         wr_q  <= {AW{1'b0}};
         cnt_q <= {(AW+1){1'b0}};
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/segasys1_mainio.sv
// Main-CPU I/O port decode, video-mode latch, sound-command queue and VBLANK IRQ.
// Optional status port at 5'h1A enabled by SEGASYS1_MAINIO_SCMD_STATUS_EN.
module segasys1_mainio
   import segasys1_mainio_pkg::*;
#(
   parameter int         NUM_INP    = 3,
   parameter int         NUM_DSW    = 2,
   parameter logic [4:0] DSW_BASE   = DSW_BASE_DEF,
   parameter int         SCMD_DEPTH = 4
)(
   input  logic                 CLK48M,
   input  logic                 RESET,
   input  logic                 CPUCE,
   input  logic [7:0]           CPUAD,
   input  logic [7:0]           CPUDO,
   input  logic                 CPUIORQ,
   input  logic                 CPURD,
   input  logic                 CPUWR,
   input  logic                 CPUM1,
   input  logic [NUM_INP*8-1:0] INP,
   input  logic [NUM_DSW*8-1:0] DSW,
   input  logic                 VBLK,
   input  logic                 SNDACK,
   output logic                 IOCS,
   output logic [7:0]           IODO,
   output logic [7:0]           VIDMODE,
   output logic                 SNDRQ,
   output logic [7:0]           SNDCMD,
   output logic                 SCMDOVF,
   output logic                 IRQ
);

   localparam int         CW      = clog2(SCMD_DEPTH) + 1;
   localparam logic [3:0] INP_LIM = NUM_INP[3:0];
   localparam logic [5:0] DSW_LIM = NUM_DSW[5:0];

   logic [4:0]    adr_s, dsw_idx_s;
   logic          inp_hit_s, dsw_hit_s, stat_hit_s, rd_en_s;
   logic          wr_s, push_s, vmode_wr_s, stat_wr_s, drop_s, empty_s;
   logic          irq_set_s, irq_ack_s;
   logic [CW-1:0] count_s;
   logic [7:0]    stat_s, vmode_q, vmode_d;
   logic          ovf_q, ovf_d, irq_q, irq_d, vblk_q;
   logic          unused_s;

   assign unused_s  = &{1'b0, CPUAD[7:5]};
   assign adr_s     = CPUAD[4:0];
   assign dsw_idx_s = adr_s - DSW_BASE;
   assign inp_hit_s = ({1'b0, adr_s[4:2]} < INP_LIM);
   assign dsw_hit_s = ({1'b0, dsw_idx_s} < DSW_LIM);
   assign stat_s    = {ovf_q, 2'b00, 5'(count_s)};
   assign rd_en_s   = CPUIORQ & CPURD & ~CPUM1;

   assign wr_s       = CPUIORQ & CPUWR & CPUCE;
   assign push_s     = wr_s & (adr_s == PA_SCMD);
   assign vmode_wr_s = wr_s & (adr_s == PA_VMODE);
   assign irq_set_s  = VBLK & ~vblk_q;
   assign irq_ack_s  = CPUCE & CPUM1 & CPUIORQ;

`ifdef SEGASYS1_MAINIO_SCMD_STATUS_EN
   assign stat_hit_s = (adr_s == PA_STAT);
   assign stat_wr_s  = wr_s & (adr_s == PA_STAT);
`else
   assign stat_hit_s = 1'b0;
   assign stat_wr_s  = 1'b0;
`endif

   segasys1_scmd_fifo #(
      .WIDTH (8),
      .DEPTH (SCMD_DEPTH)
   ) u_scmd_fifo (
      .clk_i   (CLK48M),
      .rst_i   (RESET),
      .push_i  (push_s),
      .pop_i   (SNDACK),
      .data_i  (CPUDO),
      .empty_o (empty_s),
      .drop_o  (drop_s),
      .count_o (count_s),
      .head_o  (SNDCMD)
   );

   // Read mux: input ports outrank DIP banks, which outrank the status port.
   always_comb begin
      IOCS = 1'b0;
      IODO = 8'hFF;
      if (!rd_en_s) begin
         IOCS = 1'b0;
         IODO = 8'hFF;
      end else if (inp_hit_s) begin
         IOCS = 1'b1;
         IODO = INP[{adr_s[4:2], 3'b000} +: 8];
      end else if (dsw_hit_s) begin
         IOCS = 1'b1;
         IODO = DSW[{dsw_idx_s, 3'b000} +: 8];
      end else if (stat_hit_s) begin
         IOCS = 1'b1;
         IODO = stat_s;
      end else begin
         IOCS = 1'b0;
         IODO = 8'hFF;
      end
   end

   // Next state for video latch, overflow flag and IRQ; a new VBLANK edge beats an ack.
   always_comb begin
      vmode_d = vmode_q;
      ovf_d   = ovf_q;
      irq_d   = irq_q;
      if (vmode_wr_s) vmode_d = CPUDO;
      else            vmode_d = vmode_q;
      if (stat_wr_s)   ovf_d = 1'b0;
      else if (drop_s) ovf_d = 1'b1;
      else             ovf_d = ovf_q;
      if (irq_set_s)      irq_d = 1'b1;
      else if (irq_ack_s) irq_d = 1'b0;
      else                irq_d = irq_q;
   end

   // Control registers.
   always_ff @(posedge CLK48M or posedge RESET) begin
      if (RESET) begin
         vmode_q <= 8'h00;
         ovf_q   <= 1'b0;
         irq_q   <= 1'b0;
         vblk_q  <= 1'b0;
      end else begin
         vmode_q <= vmode_d;
         ovf_q   <= ovf_d;
         irq_q   <= irq_d;
         vblk_q  <= VBLK;
      end
   end

   assign VIDMODE = vmode_q;
   assign SNDRQ   = ~empty_s;
   assign SCMDOVF = ovf_q;
   assign IRQ     = irq_q;

endmodule
